key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive synchronized samples required to accept a level change (legal 2..65535).
REQ-002 SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat press pulses while held; 0 disables them.
REQ-003 SHALL have parameter REPEAT_DELAY, default 8: cycles from initial press pulse to first repeat pulse (legal 1..65535).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 3: cycles between successive repeat pulses (legal 2..65535).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port key_in  input  1  raw asynchronous bouncing key level, 1 = pressed.
REQ-008 SHALL have port key_level  output  1  debounced key level, registered.
REQ-009 SHALL have port press_pulse  output  1  one-cycle pulse on accepted press and on each auto-repeat; serves as the count enable for the downstream counter.
REQ-010 SHALL have port release_pulse  output  1  one-cycle pulse on accepted release.

Function
REQ-011 key_in SHALL pass through a two-flop synchronizer (s1, s2); the FSM SHALL sample only s2.
REQ-012 FSM states SHALL be RELEASED, ARMING, HELD, DISARMING, with a stability counter stab_cnt and a repeat counter rep_cnt.
REQ-013 RELEASED: s2=1 -> ARMING, stab_cnt=1; s2=0 -> stay.
REQ-014 ARMING: s2=0 -> RELEASED, stab_cnt=0, no output change; s2=1 and stab_cnt=STABLE_CYCLES-1 -> HELD, key_level=1, press_pulse=1, rep_cnt=0; else stab_cnt+1.
REQ-015 Press latency: key_level and first press_pulse SHALL assert after rising edge number STABLE_CYCLES+2, counting the first edge at which key_in is sampled 1 as edge 1, given key_in held 1 throughout.
REQ-016 HELD: s2=0 -> DISARMING, stab_cnt=1; s2=1 -> rep_cnt+1 when REPEAT_EN=1.
REQ-017 Repeat: press_pulse SHALL assert when rep_cnt reaches REPEAT_DELAY, then every REPEAT_PERIOD HELD cycles thereafter; rep_cnt SHALL saturate/rewind internally, never wrap into a spurious pulse.
REQ-018 DISARMING: rep_cnt frozen; s2=1 -> HELD, stab_cnt=0, no pulse; s2=0 and stab_cnt=STABLE_CYCLES-1 -> RELEASED, key_level=0, release_pulse=1, rep_cnt=0; else stab_cnt+1.
REQ-019 press_pulse and release_pulse SHALL each be high for exactly one cycle per event and SHALL never be high in the same cycle.
REQ-020 key_level SHALL change only on the cycles in which press (first) or release pulse asserts.
REQ-021 REPEAT_EN=0: exactly one press_pulse per accepted press.

Reset
REQ-022 rst=1 at a rising edge SHALL clear s1, s2, stab_cnt, rep_cnt, key_level, press_pulse, release_pulse to 0 and force RELEASED.
REQ-023 Reset mid-operation (any state) SHALL abort in-flight debounce without emitting any pulse; a key still held after rst deasserts SHALL require full STABLE_CYCLES+2 latency to be accepted.
REQ-024 While rst=1, all outputs SHALL read 0 regardless of key_in.

Verification (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3 unless stated)
REQ-025 Clean press: key_in 0->1 sampled at edge 1, held 13 edges -> key_level=1 and press_pulse after edge 6; repeat press_pulse after edges 14, 17; no others.
REQ-026 Bounce reject: key_in high for 3 edges then low 10 -> key_level, press_pulse, release_pulse stay 0 throughout.
REQ-027 Release with glitch: from HELD, key_in low 2 edges, high 1, low 6 -> single release_pulse and key_level=0 exactly 6 edges after start of final low run; no press_pulse from glitch.
REQ-028 Hold glitch: in HELD after edge 6, key_in low edges 9-10 -> key_level stays 1, no release_pulse, first repeat delayed to after edge 16.
REQ-029 Reset mid-HELD: rst=1 for 1 edge at edge 10 with key_in held 1 -> outputs 0 after edge 10; key_level and press_pulse reassert after edge 16.
REQ-030 REPEAT_EN=0: key_in held 40 edges -> exactly one press_pulse (after edge 6), key_level=1 until release.

Source files
------------

// File: rtl/key_debounce.sv
// Debounced key with press/release pulses and optional auto-repeat.
// Raw key is double-synchronized; a four-state FSM qualifies level changes.
module key_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int STAB_W = 16;
    localparam int REP_W  = 17;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_WRAP  = REP_W'(REPEAT_DELAY + REPEAT_PERIOD);

    typedef enum logic [1:0] {
        RELEASED,
        ARMING,
        HELD,
        DISARMING
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_s1;
    logic              r_s2;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [STAB_W-1:0] w_stab_nxt;
    logic [STAB_W-1:0] w_stab_inc;
    logic [REP_W-1:0]  r_rep_cnt;
    logic [REP_W-1:0]  w_rep_nxt;
    logic [REP_W-1:0]  w_rep_inc;
    logic              w_level_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;

    assign w_stab_inc = r_stab_cnt + 1'b1;
    assign w_rep_inc  = r_rep_cnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s1 -> s2 ordering).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_state       <= RELEASED;
            r_stab_cnt    <= '0;
            r_rep_cnt     <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            r_s1          <= key_in;
            r_s2          <= r_s1;
            r_state       <= w_state_nxt;
            r_stab_cnt    <= w_stab_nxt;
            r_rep_cnt     <= w_rep_nxt;
            key_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_stab_nxt    = r_stab_cnt;
        w_rep_nxt     = r_rep_cnt;
        w_level_nxt   = key_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            RELEASED: begin
                if (r_s2) begin
                    w_state_nxt = ARMING;
                    w_stab_nxt  = STAB_W'(1);
                end
            end

            ARMING: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASED;
                    w_stab_nxt  = '0;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_state_nxt = HELD;
                    w_stab_nxt  = '0;
                    w_rep_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_stab_nxt = w_stab_inc;
                end
            end

            HELD: begin
                // Every cycle spent in HELD advances the repeat timer; the
                // count rewinds from DELAY+PERIOD to DELAY so it never wraps.
                if (REPEAT_EN != 0) begin
                    w_rep_nxt   = (w_rep_inc == REP_WRAP) ? REP_FIRST : w_rep_inc;
                    w_press_nxt = r_s2 && ((w_rep_inc == REP_FIRST) || (w_rep_inc == REP_WRAP));
                end
                if (!r_s2) begin
                    w_state_nxt = DISARMING;
                    w_stab_nxt  = STAB_W'(1);
                end
            end

            DISARMING: begin
                if (r_s2) begin
                    w_state_nxt = HELD;
                    w_stab_nxt  = '0;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_state_nxt   = RELEASED;
                    w_stab_nxt    = '0;
                    w_rep_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_stab_nxt = w_stab_inc;
                end
            end

            default: begin
                w_state_nxt = RELEASED;
            end
        endcase
    end

endmodule
